// File: rtl/v_pkg.sv
// ============================================================================
// Module      : v_pkg
// Description : Shared field types for the level-0 notify path.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package v_pkg;
    typedef logic [7:0]  id_t;
    typedef logic [31:0] key_t;
    typedef logic [15:0] size_t;
endpackage

`default_nettype wire

// File: rtl/v_lv0_notify_queue.sv
// ============================================================================
// Module      : v_lv0_notify_queue
// Description : Level-0 notify buffer with per-product coalescing behind the
//               head entry, valid/ack output and saturating drop counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module v_lv0_notify_queue #(
    parameter int DEPTH  = 4,
    parameter int OVFL_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_lv0_vld,
    input  v_pkg::id_t                   i_lv0_prod_id,
    input  v_pkg::key_t                  i_lv0_key,
    input  v_pkg::size_t                 i_lv0_size,
    output logic                         o_ntf_vld_r,
    output v_pkg::id_t                   o_ntf_prod_id_r,
    output v_pkg::key_t                  o_ntf_key_r,
    output v_pkg::size_t                 o_ntf_size_r,
    input  logic                         i_ntf_ack,
    output logic [$clog2(DEPTH+1)-1:0]   o_occ_r,
    output logic                         o_full_r,
    output logic [OVFL_W-1:0]            o_ovfl_cnt_r
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam logic [OCC_W-1:0] c_occ_full = OCC_W'(DEPTH);

    v_pkg::id_t   id_q   [DEPTH];
    v_pkg::key_t  key_q  [DEPTH];
    v_pkg::size_t size_q [DEPTH];
    v_pkg::id_t   id_d   [DEPTH];
    v_pkg::key_t  key_d  [DEPTH];
    v_pkg::size_t size_d [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [OVFL_W-1:0] ovfl_q, ovfl_d;
    logic              full_q, full_d;
    logic              ntf_vld_q, ntf_vld_d;
    v_pkg::id_t        ntf_id_q, ntf_id_d;
    v_pkg::key_t       ntf_key_q, ntf_key_d;
    v_pkg::size_t      ntf_size_q, ntf_size_d;

    logic [DEPTH-1:0]  w_match;
    logic              w_any_match;
    logic              w_pop;
    logic              w_alloc;

    // An entry is a coalescing candidate only if it is live and not the head,
    // so the head fields never change under a stalled consumer.
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_match
            logic [PTR_W-1:0] w_off;
            assign w_off      = PTR_W'(g) - rd_ptr_q;
            assign w_match[g] = (w_off != '0) && (OCC_W'(w_off) < occ_q) &&
                                (id_q[g] == i_lv0_prod_id);
        end
    endgenerate

    assign w_any_match = |w_match;
    assign w_pop       = ntf_vld_q & i_ntf_ack;

    always_comb begin
        id_d     = id_q;
        key_d    = key_q;
        size_d   = size_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        ovfl_d   = ovfl_q;
        w_alloc  = 1'b0;

        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (i_lv0_vld) begin
            if (w_any_match) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_match[i]) begin
                        key_d[i]  = i_lv0_key;
                        size_d[i] = i_lv0_size;
                    end
                end
            end else if ((occ_q != c_occ_full) || w_pop) begin
                w_alloc          = 1'b1;
                id_d[wr_ptr_q]   = i_lv0_prod_id;
                key_d[wr_ptr_q]  = i_lv0_key;
                size_d[wr_ptr_q] = i_lv0_size;
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end else if (ovfl_q != '1) begin
                ovfl_d = ovfl_q + 1'b1;
            end
        end

        occ_d = occ_q;
        if (w_alloc && !w_pop) begin
            occ_d = occ_q + 1'b1;
        end else if (!w_alloc && w_pop) begin
            occ_d = occ_q - 1'b1;
        end

        full_d    = (occ_d == c_occ_full);
        ntf_vld_d = (occ_d != '0);
        // Head is taken from next-state storage so a coalesce into the entry
        // just behind a popped head is visible as soon as it becomes head.
        if (ntf_vld_d) begin
            ntf_id_d   = id_d[rd_ptr_d];
            ntf_key_d  = key_d[rd_ptr_d];
            ntf_size_d = size_d[rd_ptr_d];
        end else begin
            ntf_id_d   = '0;
            ntf_key_d  = '0;
            ntf_size_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]   <= '0;
                key_q[i]  <= '0;
                size_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            occ_q      <= '0;
            ovfl_q     <= '0;
            full_q     <= 1'b0;
            ntf_vld_q  <= 1'b0;
            ntf_id_q   <= '0;
            ntf_key_q  <= '0;
            ntf_size_q <= '0;
        end else begin
            id_q       <= id_d;
            key_q      <= key_d;
            size_q     <= size_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            occ_q      <= occ_d;
            ovfl_q     <= ovfl_d;
            full_q     <= full_d;
            ntf_vld_q  <= ntf_vld_d;
            ntf_id_q   <= ntf_id_d;
            ntf_key_q  <= ntf_key_d;
            ntf_size_q <= ntf_size_d;
        end
    end

    a_single_match : assert property (@(posedge clk) disable iff (!rst_n)
        i_lv0_vld |-> $onehot0(w_match));

    assign o_ntf_vld_r     = ntf_vld_q;
    assign o_ntf_prod_id_r = ntf_id_q;
    assign o_ntf_key_r     = ntf_key_q;
    assign o_ntf_size_r    = ntf_size_q;
    assign o_occ_r         = occ_q;
    assign o_full_r        = full_q;
    assign o_ovfl_cnt_r    = ovfl_q;

endmodule

`default_nettype wire

// File: tb/tb_v_lv0_notify_queue.sv
// ============================================================================
// Module      : tb_v_lv0_notify_queue
// Description : Directed self-checking bench for v_lv0_notify_queue (DEPTH=4).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_v_lv0_notify_queue;

    localparam int DEPTH  = 4;
    localparam int OVFL_W = 3;

    logic               clk;
    logic               rst_n;
    logic               i_lv0_vld;
    v_pkg::id_t         i_lv0_prod_id;
    v_pkg::key_t        i_lv0_key;
    v_pkg::size_t       i_lv0_size;
    logic               o_ntf_vld_r;
    v_pkg::id_t         o_ntf_prod_id_r;
    v_pkg::key_t        o_ntf_key_r;
    v_pkg::size_t       o_ntf_size_r;
    logic               i_ntf_ack;
    logic [2:0]         o_occ_r;
    logic               o_full_r;
    logic [OVFL_W-1:0]  o_ovfl_cnt_r;

    int n_chk;
    int n_pass;

    v_lv0_notify_queue #(
        .DEPTH  (DEPTH),
        .OVFL_W (OVFL_W)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_lv0_vld       (i_lv0_vld),
        .i_lv0_prod_id   (i_lv0_prod_id),
        .i_lv0_key       (i_lv0_key),
        .i_lv0_size      (i_lv0_size),
        .o_ntf_vld_r     (o_ntf_vld_r),
        .o_ntf_prod_id_r (o_ntf_prod_id_r),
        .o_ntf_key_r     (o_ntf_key_r),
        .o_ntf_size_r    (o_ntf_size_r),
        .i_ntf_ack       (i_ntf_ack),
        .o_occ_r         (o_occ_r),
        .o_full_r        (o_full_r),
        .o_ovfl_cnt_r    (o_ovfl_cnt_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input int key, input int size);
        i_lv0_vld     = 1'b1;
        i_lv0_prod_id = v_pkg::id_t'(id);
        i_lv0_key     = v_pkg::key_t'(key);
        i_lv0_size    = v_pkg::size_t'(size);
        tick();
        i_lv0_vld     = 1'b0;
    endtask

    initial begin
        n_chk         = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        i_ntf_ack     = 1'b0;
        i_lv0_vld     = 1'b1;
        i_lv0_prod_id = 8'd9;
        i_lv0_key     = 32'h55;
        i_lv0_size    = 16'd7;

        // Reset with traffic present
        tick();
        tick();
        rst_n     = 1'b1;
        i_lv0_vld = 1'b0;
        chk("rst_vld",  32'(o_ntf_vld_r), 32'd0);
        chk("rst_occ",  32'(o_occ_r), 32'd0);
        chk("rst_full", 32'(o_full_r), 32'd0);
        chk("rst_ovfl", 32'(o_ovfl_cnt_r), 32'd0);
        chk("rst_id",   32'(o_ntf_prod_id_r), 32'd0);
        tick();
        chk("rst_hold_occ", 32'(o_occ_r), 32'd0);

        // Passthrough
        i_ntf_ack = 1'b1;
        push(3, 32'h10, 5);
        chk("pt_vld",  32'(o_ntf_vld_r), 32'd1);
        chk("pt_id",   32'(o_ntf_prod_id_r), 32'd3);
        chk("pt_key",  o_ntf_key_r, 32'h10);
        chk("pt_size", 32'(o_ntf_size_r), 32'd5);
        tick();
        chk("pt_vld2", 32'(o_ntf_vld_r), 32'd0);
        chk("pt_occ2", 32'(o_occ_r), 32'd0);

        // Sustained push+pop every cycle
        for (int i = 0; i < 8; i++) begin
            push(16 + i, 32'h100 + i, i);
        end
        chk("thr_occ",  32'(o_occ_r), 32'd1);
        chk("thr_id",   32'(o_ntf_prod_id_r), 32'd23);
        chk("thr_ovfl", 32'(o_ovfl_cnt_r), 32'd0);
        tick();
        chk("thr_empty", 32'(o_occ_r), 32'd0);

        // Coalesce behind the head
        i_ntf_ack = 1'b0;
        push(1, 32'hA, 1);
        push(2, 32'h11, 4);
        push(2, 32'h20, 9);
        chk("co_occ", 32'(o_occ_r), 32'd2);
        chk("co_id1", 32'(o_ntf_prod_id_r), 32'd1);
        i_ntf_ack = 1'b1;
        tick();
        chk("co_id2",   32'(o_ntf_prod_id_r), 32'd2);
        chk("co_key2",  o_ntf_key_r, 32'h20);
        chk("co_size2", 32'(o_ntf_size_r), 32'd9);
        tick();
        chk("co_empty", 32'(o_ntf_vld_r), 32'd0);

        // Head is never coalesced into
        i_ntf_ack = 1'b0;
        push(7, 32'h1, 1);
        push(7, 32'h2, 2);
        chk("hx_occ",  32'(o_occ_r), 32'd2);
        chk("hx_key1", o_ntf_key_r, 32'h1);
        i_ntf_ack = 1'b1;
        tick();
        chk("hx_key2", o_ntf_key_r, 32'h2);
        chk("hx_occ2", 32'(o_occ_r), 32'd1);
        tick();
        chk("hx_empty", 32'(o_ntf_vld_r), 32'd0);

        // Overflow
        i_ntf_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(i, 32'h30 + i, i);
        end
        chk("of_occ",  32'(o_occ_r), 32'd4);
        chk("of_full", 32'(o_full_r), 32'd1);
        chk("of_ovfl", 32'(o_ovfl_cnt_r), 32'd1);
        push(2, 32'h99, 8);
        chk("of_co_ovfl", 32'(o_ovfl_cnt_r), 32'd1);
        chk("of_co_occ",  32'(o_occ_r), 32'd4);
        i_ntf_ack = 1'b1;
        push(5, 32'h35, 5);
        i_ntf_ack = 1'b0;
        chk("of_pp_occ",  32'(o_occ_r), 32'd4);
        chk("of_pp_head", 32'(o_ntf_prod_id_r), 32'd1);
        chk("of_pp_full", 32'(o_full_r), 32'd1);
        chk("of_pp_ovfl", 32'(o_ovfl_cnt_r), 32'd1);
        i_ntf_ack = 1'b1;
        tick();
        i_ntf_ack = 1'b0;
        chk("of_co_id",   32'(o_ntf_prod_id_r), 32'd2);
        chk("of_co_key",  o_ntf_key_r, 32'h99);
        chk("of_co_size", 32'(o_ntf_size_r), 32'd8);
        chk("of_occ3",    32'(o_occ_r), 32'd3);
        chk("of_full0",   32'(o_full_r), 32'd0);

        // Drop counter saturation (queue holds ids 2,3,5 then 4)
        push(4, 32'h34, 4);
        chk("sat_occ", 32'(o_occ_r), 32'd4);
        for (int i = 0; i < 6; i++) begin
            push(6, 32'h36, 6);
        end
        chk("sat_max", 32'(o_ovfl_cnt_r), 32'd7);
        push(6, 32'h36, 6);
        chk("sat_hold", 32'(o_ovfl_cnt_r), 32'd7);
        chk("sat_head", 32'(o_ntf_prod_id_r), 32'd2);

        // Reset mid-operation
        i_ntf_ack = 1'b1;
        tick();
        i_ntf_ack = 1'b0;
        chk("mr_occ3", 32'(o_occ_r), 32'd3);
        rst_n     = 1'b0;
        i_lv0_vld = 1'b1;
        tick();
        rst_n     = 1'b1;
        i_lv0_vld = 1'b0;
        chk("mr_occ",  32'(o_occ_r), 32'd0);
        chk("mr_vld",  32'(o_ntf_vld_r), 32'd0);
        chk("mr_ovfl", 32'(o_ovfl_cnt_r), 32'd0);
        chk("mr_full", 32'(o_full_r), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/v_lv0_notify_queue.md
# v_lv0_notify_queue

Downstream consumer of the update pipeline's level-0 notify bus. It buffers top-of-book notifications and presents them one at a time on a valid/ack output to the market-data publisher. While an entry is waiting, a newer notification for the same product overwrites it in place, so only the latest level-0 state is published. The update pipeline has no backpressure, so this block absorbs publisher stalls and counts the notifications it has to drop.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; must be a power of 2 and at least 2
- OVFL_W, 16, width of the drop counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- i_lv0_vld  in  1  notification valid (one per cycle at most)
- i_lv0_prod_id  in  v_pkg::id_t  product id
- i_lv0_key  in  v_pkg::key_t  new level-0 key
- i_lv0_size  in  v_pkg::size_t  new level-0 size
- o_ntf_vld_r  out  1  head entry valid
- o_ntf_prod_id_r  out  v_pkg::id_t  head product id
- o_ntf_key_r  out  v_pkg::key_t  head key
- o_ntf_size_r  out  v_pkg::size_t  head size
- i_ntf_ack  in  1  consumer accepts the head entry
- o_occ_r  out  $clog2(DEPTH+1)  number of valid entries
- o_full_r  out  1  o_occ_r == DEPTH
- o_ovfl_cnt_r  out  OVFL_W  saturating count of dropped notifications

## Operation
- Storage: DEPTH entries, each holding prod_id, key and size. Read pointer rd_ptr and write pointer wr_ptr are log2(DEPTH) bits wide and wrap naturally. The occupancy counter gives the full/empty state.
- Pop: occurs when o_ntf_vld_r & i_ntf_ack. rd_ptr advances and occupancy decrements. An ack while o_ntf_vld_r = 0 is ignored.
- Push classification, for each cycle with i_lv0_vld = 1:
  - Match search: compare i_lv0_prod_id against every valid entry except the head (the entry at rd_ptr). The head is excluded whether or not it is being popped this cycle.
  - Coalesce: on a match, overwrite that entry's key and size. Occupancy and pointers are unchanged. The entry keeps its position in the queue.
  - Allocate: with no match, write the notification at wr_ptr and advance wr_ptr, provided occupancy < DEPTH or a pop occurs in the same cycle.
  - Drop: with no match, occupancy == DEPTH and no pop, the notification is discarded. o_ovfl_cnt_r increments and saturates at all-ones.
- Invariant: at most one non-head entry per prod_id. A prod_id may additionally appear in the head entry. More than one non-head match is a design error and is flagged by an assertion.
- Push and pop in the same cycle: occupancy is unchanged. When full, the allocation is accepted.
- o_full_r is registered and equals the next-state value of (occupancy == DEPTH).

## Timing
- Reset (rst_n low at a clock edge):
  - rd_ptr = 0, wr_ptr = 0, occupancy = 0.
  - o_ntf_vld_r = 0, o_occ_r = 0, o_full_r = 0, o_ovfl_cnt_r = 0.
  - o_ntf_prod_id_r, o_ntf_key_r and o_ntf_size_r read 0.
- Reset mid-operation discards every buffered entry. Inputs sampled during reset are ignored.
- Latency: a notification allocated into an empty queue at edge N is on the outputs with o_ntf_vld_r = 1 after edge N. There is no same-cycle bypass.
- Output stability: the head fields stay stable while o_ntf_vld_r = 1 and i_ntf_ack = 0, because the head is never coalesced into.
- Throughput: one push and one pop per cycle are sustained indefinitely without drops.
- All outputs are registered. There is no combinational path from i_ntf_ack or i_lv0_* to any output.

## Test plan
All scenarios use DEPTH = 4.
- Reset: hold rst_n = 0 for 2 cycles with i_lv0_vld = 1 -> o_ntf_vld_r = 0, o_occ_r = 0, o_full_r = 0 and o_ovfl_cnt_r = 0 on release.
- Passthrough: i_ntf_ack = 1; push id = 3, key = 0x10, size = 5 at edge N -> after edge N, o_ntf_vld_r = 1 with 3/0x10/5; after edge N+1, o_ntf_vld_r = 0 and o_occ_r = 0.
- Coalesce: i_ntf_ack = 0; push id 1, then id 2 (key 0x11, size 4), then id 2 (key 0x20, size 9) -> o_occ_r = 2. Acking twice returns id 1, then id 2 with key 0x20 and size 9.
- Head exclusion: i_ntf_ack = 0; push id 7 (key 0x1), then id 7 (key 0x2) -> o_occ_r = 2 and the head still reads key 0x1. Ack returns key 0x1, then key 0x2.
- Overflow:
  - i_ntf_ack = 0; push ids 0 to 4 -> o_occ_r = 4, o_full_r = 1, o_ovfl_cnt_r = 1 (id 4 dropped).
  - Then push id 2 -> coalesced, o_ovfl_cnt_r stays 1.
  - Then push id 5 with i_ntf_ack = 1 in the same cycle -> id 0 popped, id 5 accepted, o_occ_r stays 4.
- Saturation and reset mid-operation:
  - Force o_ovfl_cnt_r to all-ones and drop once more -> value stays all-ones.
  - Assert rst_n = 0 with o_occ_r = 3 -> o_occ_r = 0 and o_ntf_vld_r = 0 on the next cycle.
